// File: rtl/trig_record_reader.sv
// trig_record_reader: buffers trigger records (bitmask + timestamp) in a small
// FIFO and sends each one as a framed byte packet over a valid/ready stream:
// SYNC_BYTE, trigger mask, then the timestamp bytes MSB first.
// Optional build macro TRIG_READER_CHECKSUM_EN appends one trailing byte that
// is the XOR of every byte after SYNC_BYTE.
module trig_record_reader #(
   parameter int         DEPTH     = 8,
   parameter int         TS_W      = 56,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                     clk_adc,
   input  logic                     reset,
   input  logic                     rec_valid,
   input  logic [7:0]               rec_trig,
   input  logic [TS_W-1:0]          rec_time,
   input  logic                     flush,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [7:0]               drop_count,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = 8 + TS_W;
`ifdef TRIG_READER_CHECKSUM_EN
   localparam int NBYTES = TS_W / 8 + 3;
`else
   localparam int NBYTES = TS_W / 8 + 2;
`endif
   localparam int IW = $clog2(NBYTES);

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
`ifdef TRIG_READER_CHECKSUM_EN
   localparam logic [IW-1:0] IDX_CSUM_PREV = IW'(NBYTES - 2);
`endif

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [RW-1:0]   shreg_q, shreg_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_q, drop_d;
`ifdef TRIG_READER_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic [RW-1:0]   mem [DEPTH];
   logic [RW-1:0]   din;
   logic [RW-1:0]   head;
   logic            accept;
   logic            last_accept;
   logic            pop;
   logic            push;
   logic            drop;

   assign din         = {rec_trig, rec_time};
   // An empty FIFO can only be popped while a same-cycle push is landing, so
   // the incoming record is forwarded straight to the shift register.
   assign head        = (count_q == '0) ? din : mem[rd_ptr_q];
   assign accept      = tx_valid_q && tx_ready;
   assign last_accept = (state_q == SEND) && accept && (idx_q == IDX_LAST);
   assign pop         = !flush && (((state_q == IDLE) && (count_q != '0)) ||
                                   (last_accept && ((count_q != '0) || rec_valid)));
   assign push        = !flush && rec_valid && ((count_q != CNT_FULL) || pop);
   assign drop        = !flush && rec_valid && !push;

   // Record storage; contents need no reset because count gates every read.
   always_ff @(posedge clk_adc) begin
      if (push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Next-state logic for the FIFO bookkeeping and the packet framer FSM.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      shreg_d    = shreg_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
`ifdef TRIG_READER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      if (flush) begin
         state_d    = IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         idx_d      = '0;
         tx_data_d  = '0;
         tx_valid_d = 1'b0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
               drop_d = drop_q + 8'd1;
            end
         end
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_d = head;
                  state_d = LOAD;
               end
            end
            LOAD: begin
               tx_data_d  = SYNC_BYTE;
               tx_valid_d = 1'b1;
               idx_d      = '0;
`ifdef TRIG_READER_CHECKSUM_EN
               csum_d     = '0;
`endif
               state_d    = SEND;
            end
            SEND: begin
               if (accept) begin
                  if (idx_q == IDX_LAST) begin
                     tx_valid_d = 1'b0;
                     if (pop) begin
                        shreg_d = head;
                        state_d = LOAD;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     idx_d     = idx_q + IDX_ONE;
                     tx_data_d = shreg_q[RW-1 -: 8];
                     shreg_d   = {shreg_q[RW-9:0], 8'h00};
`ifdef TRIG_READER_CHECKSUM_EN
                     if (idx_q != '0) begin
                        csum_d = csum_q ^ tx_data_q;
                     end
                     if (idx_q == IDX_CSUM_PREV) begin
                        tx_data_d = csum_q ^ tx_data_q;
                     end
`endif
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk_adc or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         shreg_q    <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
`ifdef TRIG_READER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         shreg_q    <= shreg_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
`ifdef TRIG_READER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_trig_record_reader.sv
// Testbench for trig_record_reader: a byte-level scoreboard fed by a packet
// model, a monitor that pops and compares every accepted byte, and directed
// plus randomized record traffic.
module tb_trig_record_reader;

   localparam int DEPTH = 8;
   localparam int TS_W  = 56;
`ifdef TRIG_READER_CHECKSUM_EN
   localparam int PKT = TS_W / 8 + 3;
`else
   localparam int PKT = TS_W / 8 + 2;
`endif

   logic                   clk_adc = 1'b0;
   logic                   reset;
   logic                   rec_valid;
   logic [7:0]             rec_trig;
   logic [TS_W-1:0]        rec_time;
   logic                   flush;
   logic [7:0]             tx_data;
   logic                   tx_valid;
   logic                   tx_ready = 1'b0;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   overflow;
   logic [7:0]             drop_count;
   logic                   busy;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   int         ready_mode  = 0;
   logic       ready_hold  = 1'b0;
   bit         gap_check   = 1'b0;

   trig_record_reader #(.DEPTH(DEPTH), .TS_W(TS_W), .SYNC_BYTE(8'hA5)) dut (
      .clk_adc    (clk_adc),
      .reset      (reset),
      .rec_valid  (rec_valid),
      .rec_trig   (rec_trig),
      .rec_time   (rec_time),
      .flush      (flush),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .drop_count (drop_count),
      .busy       (busy)
   );

   // Free-running clock.
   initial begin
      forever #5 clk_adc = ~clk_adc;
   end

   // Downstream ready: held, toggling every cycle, or random.
   initial begin
      forever begin
         @(posedge clk_adc);
         #2;
         case (ready_mode)
            0:       tx_ready = ready_hold;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: compares every accepted byte, stall stability and packet gaps.
   initial begin
      bit         prev_stall  = 1'b0;
      bit         prev_flush  = 1'b0;
      logic [7:0] prev_data   = 8'h00;
      bit         gap_active  = 1'b0;
      int         gap_len     = 0;
      logic [7:0] exp_byte;
      forever begin
         @(negedge clk_adc);
         if (reset) begin
            prev_stall = 1'b0;
            gap_active = 1'b0;
         end else begin
            if (prev_stall && !prev_flush) begin
               vectors++;
               if (!(tx_valid === 1'b1 && tx_data === prev_data)) begin
                  miscompares++;
                  $display("[TB] FAIL stall_hold: got valid=%0b data=%02h, required valid=1 data=%02h",
                           tx_valid, tx_data, prev_data);
               end
            end
            if (gap_check && gap_active) begin
               if (tx_valid) begin
                  vectors++;
                  gap_active = 1'b0;
                  if (gap_len != 1) begin
                     miscompares++;
                     $display("[TB] FAIL packet_gap: got %0d idle cycles, required 1", gap_len);
                  end
               end else begin
                  gap_len++;
               end
            end
            if (tx_valid && tx_ready) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL unexpected_byte: got %02h, required no byte", tx_data);
               end else begin
                  exp_byte = exp_q.pop_front();
                  if (tx_data !== exp_byte) begin
                     miscompares++;
                     $display("[TB] FAIL tx_byte: got %02h, required %02h", tx_data, exp_byte);
                  end
                  if (gap_check && exp_q.size() != 0 && (exp_q.size() % PKT) == 0) begin
                     gap_active = 1'b1;
                     gap_len    = 0;
                  end
               end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_flush = flush;
         end
      end
   end

   // Reference packet: sync, trigger mask, timestamp MSB first, optional XOR.
   task automatic expectPacket(input logic [7:0] trig, input logic [TS_W-1:0] ts);
      logic [7:0] b;
      logic [7:0] x;
      x = trig;
      exp_q.push_back(8'hA5);
      exp_q.push_back(trig);
      for (int k = TS_W / 8 - 1; k >= 0; k--) begin
         b = 8'(ts >> (8 * k));
         exp_q.push_back(b);
         x = x ^ b;
      end
`ifdef TRIG_READER_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_adc);
         #1;
      end
   endtask

   // One write strobe, captured on the next edge; queue its bytes if it will be sent.
   task automatic applyStimulus(input logic [7:0] trig, input logic [TS_W-1:0] ts,
                                input bit will_send);
      rec_valid = 1'b1;
      rec_trig  = trig;
      rec_time  = ts;
      if (will_send) expectPacket(trig, ts);
      @(posedge clk_adc);
      #1;
      rec_valid = 1'b0;
   endtask

   task automatic applyRandom(input bit will_send);
      logic [63:0] r;
      r = {$urandom, $urandom};
      applyStimulus(8'($urandom), r[TS_W-1:0], will_send);
   endtask

   task automatic waitDrain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk_adc);
         n++;
      end
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: got %0d bytes pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic doFlush();
      exp_q.delete();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
   endtask

   int outstanding;

   initial begin
      reset     = 1'b1;
      rec_valid = 1'b0;
      rec_trig  = '0;
      rec_time  = '0;
      flush     = 1'b0;

      // Reset values while reset is held.
      @(posedge clk_adc);
      #1;
      checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
      checkOutput("rst_fifo_count", 64'(fifo_count), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      checkOutput("rst_drop_count", 64'(drop_count), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      #2;
      reset = 1'b0;
      cyc(1);

      // Single record with latency check.
      $display("[TB] single record");
      ready_hold = 1'b1;
      cyc(1);
      applyStimulus(8'h05, 56'h1234, 1'b1);
      @(negedge clk_adc);
      checkOutput("lat_edge_n", 64'(tx_valid), 64'd0);
      @(negedge clk_adc);
      checkOutput("lat_edge_n1", 64'(tx_valid), 64'd0);
      checkOutput("lat_busy_load", 64'(busy), 64'd1);
      @(negedge clk_adc);
      checkOutput("lat_edge_n2_valid", 64'(tx_valid), 64'd1);
      checkOutput("lat_edge_n2_sync", 64'(tx_data), 64'hA5);
      waitDrain(50);
      @(negedge clk_adc);
      checkOutput("single_end_valid", 64'(tx_valid), 64'd0);
      checkOutput("single_end_busy", 64'(busy), 64'd0);
      cyc(1);

      // Back-to-back records with toggling ready.
      $display("[TB] back-to-back");
      ready_mode = 1;
      gap_check  = 1'b1;
      repeat (3) applyRandom(1'b1);
      waitDrain(200);
      gap_check  = 1'b0;
      ready_mode = 0;
      ready_hold = 1'b0;
      cyc(3);

      // Overflow with the first record popped into the framer.
      $display("[TB] overflow, first record popped");
      repeat (10) applyRandom(1'b0);
      checkOutput("ovfA_fifo_count", 64'(fifo_count), 64'd8);
      checkOutput("ovfA_drop_count", 64'(drop_count), 64'd1);
      checkOutput("ovfA_overflow", 64'(overflow), 64'd1);
      checkOutput("ovfA_busy", 64'(busy), 64'd1);
      doFlush();
      checkOutput("flushA_fifo_count", 64'(fifo_count), 64'd0);
      checkOutput("flushA_drop_count", 64'(drop_count), 64'd0);
      checkOutput("flushA_overflow", 64'(overflow), 64'd0);
      checkOutput("flushA_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("flushA_busy", 64'(busy), 64'd0);

      // Overflow while a stalled packet is already in flight, then saturation.
      $display("[TB] overflow, packet already in flight");
      applyRandom(1'b0);
      cyc(3);
      repeat (10) applyRandom(1'b0);
      checkOutput("ovfB_fifo_count", 64'(fifo_count), 64'd8);
      checkOutput("ovfB_drop_count", 64'(drop_count), 64'd2);
      repeat (260) applyRandom(1'b0);
      checkOutput("ovfB_drop_sat", 64'(drop_count), 64'd255);
      checkOutput("ovfB_overflow", 64'(overflow), 64'd1);
      doFlush();
      checkOutput("flushB_drop_count", 64'(drop_count), 64'd0);
      checkOutput("flushB_overflow", 64'(overflow), 64'd0);
      checkOutput("flushB_fifo_count", 64'(fifo_count), 64'd0);

      // Push/pop collision: full FIFO, strobe on the last-byte acceptance.
      $display("[TB] push/pop collision");
      applyRandom(1'b1);
      cyc(3);
      repeat (8) applyRandom(1'b1);
      checkOutput("coll_full", 64'(fifo_count), 64'd8);
      ready_hold = 1'b1;
      cyc(PKT - 1);
      applyRandom(1'b1);
      checkOutput("coll_fifo_count", 64'(fifo_count), 64'd8);
      checkOutput("coll_drop_count", 64'(drop_count), 64'd0);
      checkOutput("coll_overflow", 64'(overflow), 64'd0);
      waitDrain(300);
      cyc(2);
      checkOutput("coll_end_count", 64'(fifo_count), 64'd0);

      // Flush after four bytes of a packet.
      $display("[TB] flush mid-packet");
      ready_hold = 1'b0;
      cyc(2);
      applyRandom(1'b1);
      cyc(2);
      ready_hold = 1'b1;
      cyc(4);
      ready_hold = 1'b0;
      doFlush();
      checkOutput("fmid_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("fmid_busy", 64'(busy), 64'd0);
      ready_hold = 1'b1;
      cyc(1);
      applyRandom(1'b1);
      waitDrain(50);
      cyc(2);

      // Asynchronous reset in the middle of a packet.
      $display("[TB] async reset mid-packet");
      applyRandom(1'b1);
      cyc(4);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("areset_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("areset_tx_data", 64'(tx_data), 64'd0);
      checkOutput("areset_busy", 64'(busy), 64'd0);
      checkOutput("areset_fifo_count", 64'(fifo_count), 64'd0);
      #3;
      reset = 1'b0;
      cyc(12);
      checkOutput("areset_after_valid", 64'(tx_valid), 64'd0);
      checkOutput("areset_after_count", 64'(fifo_count), 64'd0);

      // Randomized traffic, kept below the drop threshold.
      $display("[TB] random traffic");
      ready_mode = 2;
      for (int i = 0; i < 400; i++) begin
         outstanding = (exp_q.size() + PKT - 1) / PKT;
         if ($urandom_range(0, 2) == 0 && outstanding < DEPTH - 1) begin
            applyRandom(1'b1);
         end else begin
            cyc(1);
         end
      end
      ready_mode = 0;
      ready_hold = 1'b1;
      waitDrain(1000);
      cyc(2);
      checkOutput("rand_end_count", 64'(fifo_count), 64'd0);
      checkOutput("rand_end_overflow", 64'(overflow), 64'd0);
      checkOutput("rand_end_valid", 64'(tx_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
